// File: rtl/inst_sram_responder.sv
// Instruction fetch responder: word-addressed instruction memory with a fixed,
// parameterised wait-state latency, a host preload port, and a PC stall request.
module inst_sram_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'hbfc00000,
  parameter int          DEPTH_LOG2  = 10,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_en,
  input  logic [31:0]           req_addr,
  output logic                  req_ready,
  output logic                  stall_req,
  input  logic                  flush,
  output logic                  resp_valid,
  output logic [31:0]           resp_inst,
  output logic [31:0]           resp_pc,
  output logic                  resp_err,
  input  logic                  load_en,
  input  logic [DEPTH_LOG2-1:0] load_addr,
  input  logic [31:0]           load_data
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t                r_state;
  logic [3:0]            r_cnt;
  logic [31:0]           r_pend_addr;
  logic                  r_pend_err;
  logic [DEPTH_LOG2-1:0] r_pend_idx;
  logic [31:0]           r_resp_inst;
  logic [31:0]           r_resp_pc;
  logic                  r_resp_err;

  logic [31:0]           r_mem [0:(1<<DEPTH_LOG2)-1];

  logic [31:2]           w_req_off;
  logic                  w_req_err;
  logic [DEPTH_LOG2-1:0] w_req_idx;
  logic                  w_accept;
  logic                  w_drop;

  // Word offset from the base; any set bit above the window means out of range.
  assign w_req_off = req_addr[31:2] - BASE_ADDR[31:2];
  assign w_req_err = (req_addr[1:0] != 2'b00) | (|w_req_off[31:DEPTH_LOG2+2]);
  assign w_req_idx = w_req_off[DEPTH_LOG2+1:2];

  // A flush opens the interface for the redirect fetch even while waiting.
  assign w_accept = req_en & ((r_state != S_WAIT) | flush);
  assign w_drop   = flush & ~req_en;

  assign req_ready  = (r_state != S_WAIT);
  assign stall_req  = ~req_ready;
  assign resp_valid = (r_state == S_RESP) & ~flush;
  assign resp_inst  = r_resp_inst;
  assign resp_pc    = r_resp_pc;
  assign resp_err   = r_resp_err;

  // Preload port; not reset, and a same-edge read sees the old word.
  always_ff @(posedge clk) begin
    if (load_en) begin
      r_mem[load_addr] <= load_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_pend_addr <= 32'd0;
      r_pend_err  <= 1'b0;
      r_pend_idx  <= '0;
      r_resp_inst <= 32'd0;
      r_resp_pc   <= 32'd0;
      r_resp_err  <= 1'b0;
    end else if (w_drop) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else if (w_accept) begin
      r_pend_addr <= req_addr;
      r_pend_err  <= w_req_err;
      r_pend_idx  <= w_req_idx;
      if (WAIT_CYCLES == 0) begin
        r_state     <= S_RESP;
        r_resp_pc   <= req_addr;
        r_resp_err  <= w_req_err;
        r_resp_inst <= w_req_err ? 32'd0 : r_mem[w_req_idx];
      end else begin
        r_state <= S_WAIT;
        r_cnt   <= WAIT_INIT;
      end
    end else begin
      case (r_state)
        S_WAIT: begin
          if (r_cnt == 4'd1) begin
            r_state     <= S_RESP;
            r_cnt       <= 4'd0;
            r_resp_pc   <= r_pend_addr;
            r_resp_err  <= r_pend_err;
            r_resp_inst <= r_pend_err ? 32'd0 : r_mem[r_pend_idx];
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_sram_responder.sv
// Bench for inst_sram_responder: three instances (0, 2, 3 wait states) share
// stimulus and are compared every cycle against a timeline-based reference model.
module tb_inst_sram_responder;

  localparam logic [31:0] BASE = 32'hbfc00000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0, fl = 1'b0, ld = 1'b0;
  logic [31:0] addr = 32'd0, ldata = 32'd0;
  logic [9:0]  laddr = 10'd0;

  logic        o_rdy [3];
  logic        o_stall [3];
  logic        o_vld [3];
  logic [31:0] o_inst [3];
  logic [31:0] o_pc [3];
  logic        o_err [3];

  int errors = 0;
  int checks = 0;

  // Reference model: a fetch accepted at edge t answers in cycle t+W.
  logic [31:0] mem_m [0:1023];
  bit          m_pend [3];
  int          m_acc [3];
  logic [31:0] m_addr [3];
  logic [31:0] m_inst [3];
  bit          m_err [3];
  int          cyc = 0;

  always #5 clk = ~clk;

  inst_sram_responder #(.WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .reset(reset), .req_en(en), .req_addr(addr),
    .req_ready(o_rdy[0]), .stall_req(o_stall[0]), .flush(fl),
    .resp_valid(o_vld[0]), .resp_inst(o_inst[0]), .resp_pc(o_pc[0]), .resp_err(o_err[0]),
    .load_en(ld), .load_addr(laddr), .load_data(ldata));

  inst_sram_responder #(.WAIT_CYCLES(2)) u_w2 (
    .clk(clk), .reset(reset), .req_en(en), .req_addr(addr),
    .req_ready(o_rdy[1]), .stall_req(o_stall[1]), .flush(fl),
    .resp_valid(o_vld[1]), .resp_inst(o_inst[1]), .resp_pc(o_pc[1]), .resp_err(o_err[1]),
    .load_en(ld), .load_addr(laddr), .load_data(ldata));

  inst_sram_responder #(.WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .reset(reset), .req_en(en), .req_addr(addr),
    .req_ready(o_rdy[2]), .stall_req(o_stall[2]), .flush(fl),
    .resp_valid(o_vld[2]), .resp_inst(o_inst[2]), .resp_pc(o_pc[2]), .resp_err(o_err[2]),
    .load_en(ld), .load_addr(laddr), .load_data(ldata));

  function automatic int wc(int k);
    return (k == 0) ? 0 : ((k == 1) ? 2 : 3);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic capture(input int k);
    logic [31:0] off;
    off      = m_addr[k] - BASE;
    m_err[k] = (m_addr[k][1:0] != 2'b00) || (off >= 32'd4096);
    m_inst[k] = m_err[k] ? 32'd0 : mem_m[off >> 2];
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) m_pend[k] = 1'b0;
  endtask

  task automatic model_edge();
    int  e;
    bit  rdy;
    e = cyc + 1;
    for (int k = 0; k < 3; k++) begin
      rdy = !(m_pend[k] && cyc < m_acc[k] + wc(k));
      if (fl && !en) begin
        m_pend[k] = 1'b0;
      end else if (en && (rdy || fl)) begin
        m_pend[k] = 1'b1;
        m_acc[k]  = e;
        m_addr[k] = addr;
        if (wc(k) == 0) capture(k);
      end else if (m_pend[k] && e > m_acc[k] + wc(k)) begin
        m_pend[k] = 1'b0;
      end else if (m_pend[k] && e == m_acc[k] + wc(k)) begin
        capture(k);
      end
    end
    if (ld) mem_m[laddr] = ldata;
    cyc = e;
  endtask

  task automatic check_outputs();
    bit exp_rdy, exp_v;
    for (int k = 0; k < 3; k++) begin
      exp_rdy = !(m_pend[k] && cyc < m_acc[k] + wc(k));
      exp_v   = m_pend[k] && (cyc == m_acc[k] + wc(k)) && !fl;
      chk($sformatf("w%0d_ready", wc(k)), {31'd0, o_rdy[k]}, {31'd0, exp_rdy});
      chk($sformatf("w%0d_stall", wc(k)), {31'd0, o_stall[k]}, {31'd0, !exp_rdy});
      chk($sformatf("w%0d_valid", wc(k)), {31'd0, o_vld[k]}, {31'd0, exp_v});
      if (exp_v) begin
        chk($sformatf("w%0d_inst", wc(k)), o_inst[k], m_inst[k]);
        chk($sformatf("w%0d_pc", wc(k)), o_pc[k], m_addr[k]);
        chk($sformatf("w%0d_err", wc(k)), {31'd0, o_err[k]}, {31'd0, m_err[k]});
      end
    end
  endtask

  task automatic check_zero(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s_w%0d_valid", tag, wc(k)), {31'd0, o_vld[k]}, 32'd0);
      chk($sformatf("%s_w%0d_inst", tag, wc(k)), o_inst[k], 32'd0);
      chk($sformatf("%s_w%0d_pc", tag, wc(k)), o_pc[k], 32'd0);
      chk($sformatf("%s_w%0d_err", tag, wc(k)), {31'd0, o_err[k]}, 32'd0);
      chk($sformatf("%s_w%0d_ready", tag, wc(k)), {31'd0, o_rdy[k]}, 32'd1);
    end
  endtask

  // One clock: drive, check mid-cycle, advance model on the edge.
  task automatic cycle(input logic i_en, input logic [31:0] i_addr, input logic i_fl,
                       input logic i_ld, input logic [9:0] i_laddr, input logic [31:0] i_ldata);
    en = i_en; addr = i_addr; fl = i_fl;
    ld = i_ld; laddr = i_laddr; ldata = i_ldata;
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'd0, 1'b0, 1'b0, 10'd0, 32'd0);
  endtask

  task automatic load(input logic [9:0] a, input logic [31:0] d);
    cycle(1'b0, 32'd0, 1'b0, 1'b1, a, d);
  endtask

  task automatic fetch(input logic [31:0] a);
    cycle(1'b1, a, 1'b0, 1'b0, 10'd0, 32'd0);
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    case (r)
      7:       return BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(1, 3));
      8:       return BASE + 32'd4096 + 32'(4 * $urandom_range(0, 3));
      9:       return ($urandom_range(0, 1) == 1) ? BASE - 32'd4 : 32'h80000000;
      6:       return BASE + 32'd4092;
      default: return BASE + 32'(4 * $urandom_range(0, 15));
    endcase
  endfunction

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Preload: known program words plus random filler for the random phase.
    load(10'd0, 32'h24010001);
    load(10'd1, 32'h24020002);
    for (int i = 2; i < 16; i++) load(10'(i), $urandom);
    load(10'd1023, 32'h1234_5678);
    load(10'h0E0, 32'h42000018);

    // Back-to-back fetches, then a long-wait pair.
    fetch(BASE);
    fetch(BASE + 32'd4);
    idle(4);
    fetch(BASE);
    idle(2);
    fetch(BASE + 32'd4);
    idle(4);

    // Error fetches: misaligned and out of window.
    fetch(BASE + 32'd2);
    idle(4);
    fetch(32'h80000000);
    idle(4);
    fetch(BASE + 32'd4096);
    idle(4);

    // Flush with redirect fetch one cycle after the original request.
    fetch(BASE);
    cycle(1'b1, 32'hbfc00380, 1'b1, 1'b0, 10'd0, 32'd0);
    idle(5);
    // Flush alone while idle, and flush alone mid-wait.
    cycle(1'b0, 32'd0, 1'b1, 1'b0, 10'd0, 32'd0);
    fetch(BASE + 32'd4);
    idle(1);
    cycle(1'b0, 32'd0, 1'b1, 1'b0, 10'd0, 32'd0);
    idle(4);

    // Asynchronous reset between edges while the slow instances are waiting.
    fetch(BASE);
    idle(1);
    #1 reset = 1'b1;
    #1;
    check_zero("async_rst");
    model_reset();
    reset = 1'b0;
    #1;
    fetch(BASE);
    idle(4);

    // Load hitting the word captured on the same edge returns old data.
    cycle(1'b1, BASE, 1'b0, 1'b1, 10'd0, 32'hAAAA0000);
    idle(4);
    fetch(BASE);
    idle(4);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      logic        r_en, r_fl, r_ld;
      logic [9:0]  r_la;
      r_en = ($urandom_range(0, 99) < 55);
      r_fl = ($urandom_range(0, 99) < 8);
      r_ld = ($urandom_range(0, 99) < 20);
      r_la = ($urandom_range(0, 9) == 0) ? 10'd1023 : 10'($urandom_range(0, 15));
      cycle(r_en, rand_addr(), r_fl, r_ld, r_la, $urandom);
    end
    idle(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
